// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer driving operand/result shift registers (optional ovf port via SERIAL_ALU_OVF_EN)
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             sr_en,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_a_pin,
  output logic [WIDTH-1:0] sr_b_pin,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             res_bit,
  output logic             res_en,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             carry_out,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_SUB = 2'b01;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q, zt_q;
  logic [CW-1:0]    cnt_q;
  logic             arith, b_eff, sum_bit, maj, alu_bit, last;
  assign arith    = ~op_q[1];
  assign b_eff    = b_bit ^ (op_q == OP_SUB);
  assign sum_bit  = a_bit ^ b_eff ^ carry_q;
  assign maj      = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
  assign alu_bit  = arith ? sum_bit : op_q[0] ? a_bit ^ b_eff : a_bit & b_eff;
  assign last     = cnt_q == CW'(WIDTH - 1);
  assign sr_a_pin = a_q;
  assign sr_b_pin = b_q;
  assign carry_out = (state == DONE) & carry_q;
  assign zero      = (state == DONE) & zt_q;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // next-state and strobe decode
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    sr_en      = 1'b0;
    sr_load    = 1'b0;
    res_en     = 1'b0;
    res_bit    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = LOAD;
      end
      LOAD: begin
        sr_en    = 1'b1;
        sr_load  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        sr_en   = 1'b1;
        res_en  = 1'b1;
        res_bit = alu_bit;
        if (last) state_nx = DONE;
      end
      default: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
    endcase
  end
  // operand capture, carry chain, bit counter and zero tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      zt_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (state == IDLE && req_valid) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op;
    end else if (state == LOAD) begin
      carry_q <= op_q == OP_SUB;
      zt_q    <= 1'b1;
      cnt_q   <= '0;
    end else if (state == SHIFT) begin
      carry_q <= arith & maj;
      zt_q    <= zt_q & ~alu_bit;
      cnt_q   <= cnt_q + 1'b1;
    end
  end
`ifdef SERIAL_ALU_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
  // signed overflow: carry into MSB differs from carry out of MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf_q <= 1'b0;
    else if (state == LOAD)           ovf_q <= 1'b0;
    else if (state == SHIFT && last)  ovf_q <= arith & (carry_q ^ maj);
  end
`endif
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed bench with shift-register models and an expected-result scoreboard
module tb_serial_alu_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, resp_ready = 0;
  logic [1:0] req_op = 0;
  logic [W-1:0] req_a = 0, req_b = 0, sr_a_pin, sr_b_pin;
  logic sr_en, sr_load, a_bit, b_bit, res_bit, res_en, resp_valid, carry_out, zero;
  logic [W-1:0] ra, rb, rr;
  int checks = 0, errors = 0;
  typedef struct { logic [W-1:0] res; logic c; logic z; logic v; } exp_t;
  exp_t sb[$];
`ifdef SERIAL_ALU_OVF_EN
  logic ovf;
`endif
  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .sr_en(sr_en), .sr_load(sr_load),
    .sr_a_pin(sr_a_pin), .sr_b_pin(sr_b_pin), .a_bit(a_bit), .b_bit(b_bit),
    .res_bit(res_bit), .res_en(res_en), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .carry_out(carry_out), .zero(zero)
`ifdef SERIAL_ALU_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  assign a_bit = ra[0];
  assign b_bit = rb[0];
  // external shift registers the controller sequences
  always @(posedge clk) begin
    if (sr_en) begin
      ra <= sr_load ? sr_a_pin : ra >> 1;
      rb <= sr_load ? sr_b_pin : rb >> 1;
    end
    if (res_en) rr <= {res_bit, rr[W-1:1]};
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    e.c = 0; e.v = 0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]); end
      2'b01: begin e.res = a - b; e.c = a >= b;
        e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]); end
      2'b10: e.res = a & b;
      default: e.res = a ^ b;
    endcase
    e.z = e.res == 0;
    return e;
  endfunction
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_before_send", req_ready, 1);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    req_valid = 0;
    chk("load_strobe", {sr_en, sr_load, req_ready}, 3'b110);
  endtask
  task automatic wait_check(input string tag);
    int n = 0;
    exp_t e;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_latency"}, n, W + 1);
    if (sb.size() == 0) begin errors++; $error("FAIL %s_sb: got empty expected entry", tag); end
    else begin
      e = sb.pop_front();
      chk({tag, "_res"}, rr, e.res);
      chk({tag, "_carry"}, carry_out, e.c);
      chk({tag, "_zero"}, zero, e.z);
`ifdef SERIAL_ALU_OVF_EN
      chk({tag, "_ovf"}, ovf, e.v);
`endif
    end
  endtask
  task automatic release_resp();
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("idle_after_resp", {req_ready, resp_valid}, 2'b10);
  endtask
  initial begin
    logic hc, hz;
    #2;
    chk("reset_outputs", {req_ready, sr_en, sr_load, res_en, res_bit, resp_valid, carry_out, zero}, 8'b1000_0000);
    chk("reset_pins", {sr_a_pin, sr_b_pin}, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    send(2'b00, 8'h7F, 8'h01); wait_check("add_7f_01"); release_resp();
    send(2'b01, 8'h05, 8'h05); wait_check("sub_05_05"); release_resp();
    send(2'b00, 8'hFF, 8'h01); wait_check("add_ff_01"); release_resp();
    send(2'b01, 8'h00, 8'h01); wait_check("sub_00_01"); release_resp();
    send(2'b10, 8'hF0, 8'h3C); wait_check("and_f0_3c"); release_resp();
    send(2'b11, 8'hF0, 8'hF0); wait_check("xor_f0_f0"); release_resp();
    send(2'b00, 8'hA5, 8'h5A); wait_check("add_a5_5a");
    chk("pins_hold", {sr_a_pin, sr_b_pin}, 16'hA55A);
    hc = carry_out; hz = zero;
    req_valid = 1; req_op = 2'b01; req_a = 8'h80; req_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_state", {resp_valid, req_ready, sr_en, sr_load, carry_out, zero}, {4'b1000, hc, hz});
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("hold_release_idle", {req_ready, resp_valid}, 2'b10);
    sb.push_back(model(2'b01, 8'h80, 8'h01));
    @(posedge clk); #1;
    req_valid = 0;
    chk("next_accept_load", {sr_en, sr_load}, 2'b11);
    wait_check("sub_80_01"); release_resp();
    send(2'b00, 8'hC3, 8'h3C);
    repeat (4) @(posedge clk);
    #1;
    chk("in_shift", {sr_en, sr_load, res_en}, 3'b101);
    rst_n = 0;
    #1;
    chk("mid_reset", {req_ready, sr_en, sr_load, res_en, res_bit, resp_valid}, 6'b100000);
    void'(sb.pop_back());
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    send(2'b00, 8'h12, 8'h34); wait_check("add_12_34"); release_resp();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
